inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage that sits directly downstream of the program counter. Each cycle it samples the PC address, drives a synchronous-read instruction memory, tells the PC when to advance, and buffers returned instructions with their addresses in a 2-entry queue. The queue feeds the decode stage through a valid/ready handshake. A flush discards everything in flight for branch redirects.

## Interface
- ADDR_WIDTH, 32, width of PC / instruction address
- DATA_WIDTH, 32, instruction width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pc_address  in  ADDR_WIDTH  current fetch address from the PC
- pc_enable  out  1  PC may advance at this edge; equals the internal issue signal
- imem_addr  out  ADDR_WIDTH  memory read address; combinationally equal to pc_address
- imem_en  out  1  memory read enable; equals issue
- imem_rdata  in  DATA_WIDTH  read data, valid the cycle after imem_en
- flush  in  1  discard the queued instruction and the in-flight instruction
- inst_valid  out  1  queue head holds an instruction
- inst_ready  in  1  decode accepts the head this cycle
- inst_data  out  DATA_WIDTH  head instruction
- inst_pc  out  ADDR_WIDTH  address of the head instruction

## Operation
- State:
  - count (0..2): queue occupancy.
  - inflight (0/1): a read was issued last cycle.
  - inflight_pc: address of that read.
  - 2-entry circular queue (rd_ptr, wr_ptr), each entry {data, pc}.
- pop = inst_valid & inst_ready & !flush.
- issue = !flush & reset_released & ((count + inflight < 2) | pop).
- Invariant: count + inflight <= 2 at every edge. An issue can never overflow the queue.
- Normal edge:
  - If inflight, write {imem_rdata, inflight_pc} at wr_ptr and increment wr_ptr.
  - If pop, increment rd_ptr.
  - count' = count + inflight - pop.
  - inflight' = issue; inflight_pc' = pc_address when issue.
- Flush edge:
  - count, inflight, rd_ptr and wr_ptr all go to 0.
  - The data returning from the killed read is ignored.
  - No issue occurs in the flush cycle. The PC holds, and the redirect is the PC's responsibility.
- inst_valid = (count != 0). inst_data and inst_pc come from the entry at rd_ptr; they are 0 when the queue is empty after reset.
- Pointers wrap modulo 2.
- Simultaneous write and pop with count = 2 and inflight = 1 cannot occur, because the invariant forbids it.
- Simultaneous write and pop with count = 1: the head is replaced by the next entry and count stays 1.

## Timing
- Reset (reset = 0) asynchronously sets count = 0, inflight = 0, inflight_pc = 0, pointers = 0 and all queue entries = 0.
- Outputs during reset:
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  - pc_enable = 0 and imem_en = 0: issue is gated while reset is low.
- Reset asserted mid-operation drops all state immediately. No partial instruction is ever presented afterwards.
- Fetch latency: issue in cycle T → rdata in T+1 → inst_valid in T+2. The first issue occurs in the first cycle after reset deasserts.
- Throughput is 1 instruction/cycle while inst_ready = 1. In steady state count = 1 and inflight = 1.
- Backpressure (inst_ready = 0): issue stops once count + inflight = 2. At most 2 PC advances happen without a pop.
- Flush in cycle F: inst_valid = 0 in F+1. The first post-flush issue is in F+1 and its instruction is valid in F+3.
- Handshake: inst_data and inst_pc hold stable while inst_valid = 1 and inst_ready = 0.

## Test plan
- Reset: hold reset = 0 for 3 cycles with clock running → inst_valid = 0, pc_enable = 0, inst_pc = 0. Release → pc_enable = 1 in the next cycle.
- Stream: the PC model steps 0, 4, 8, 12, memory returns addr+0x100, inst_ready = 1 → inst_valid rises 2 cycles after the first issue. Expected output {inst_pc, inst_data} = {0,0x100}, {4,0x104}, {8,0x108}, … on consecutive cycles.
- Backpressure: inst_ready = 0 from the start → exactly 2 pc_enable pulses (PC reaches 8). Head stays {0,0x100}. Raise inst_ready → 0, 4, 8 delivered in order with no loss or duplicate.
- Flush: assert flush for 1 cycle while count = 1 and inflight = 1 → inst_valid = 0 next cycle. The killed read's data never appears. After the PC is redirected to 0x40, the first delivered instruction is {0x40,0x140}.
- Mid-operation reset: pulse reset low between edges during streaming → inst_valid drops asynchronously in the same cycle. Fetch restarts cleanly from the PC's reset address.
- Flush with inst_ready = 1 and a valid head → the head is not counted as consumed; the scoreboard sees no delivery in that cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage between the program counter and decode.
// Issues one synchronous-read request per cycle when there is room for its
// result, buffers returned instructions with their addresses in a 2-entry
// queue, and presents the queue head to decode through a valid/ready
// handshake. A flush discards both the queued and the in-flight instruction.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,       // active-low, asynchronous
  input  logic [ADDR_WIDTH-1:0] i_pc_address,
  output logic                  o_pc_enable,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic                  o_imem_en,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  input  logic                  i_flush,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [DATA_WIDTH-1:0] o_inst_data,
  output logic [ADDR_WIDTH-1:0] o_inst_pc
);

  // Queue occupancy (0..2) and the single outstanding memory read.
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  // Circular queue pointers; two entries, so one bit each wraps naturally.
  logic r_rd_ptr;
  logic r_wr_ptr;

  // Per-entry views of the queue storage, collected for the head mux.
  logic [DATA_WIDTH-1:0] w_q_data [2];
  logic [ADDR_WIDTH-1:0] w_q_pc   [2];

  logic [1:0] w_occupancy;
  logic       w_has_room;
  logic       w_pop;
  logic       w_issue;
  logic       w_write;

  // Slots already committed: queued entries plus the read still in flight.
  // Max value is 2 + 1 = 3, so two bits are enough.
  assign w_occupancy = r_count + {1'b0, r_inflight};
  assign w_has_room  = (w_occupancy < 2'd2);

  assign o_inst_valid = (r_count != 2'd0);

  // A flush cycle never counts as a delivery, even with ready high.
  assign w_pop = o_inst_valid & i_inst_ready & ~i_flush;

  // Issue only when the result is guaranteed a queue slot: either a slot is
  // free now, or the head leaves this cycle. Gated by reset so nothing is
  // requested while reset is held.
  assign w_issue = ~i_flush & i_reset & (w_has_room | w_pop);

  // Returning data is captured unless a flush kills it.
  assign w_write = r_inflight & ~i_flush;

  assign o_pc_enable = w_issue;
  assign o_imem_en   = w_issue;
  assign o_imem_addr = i_pc_address;

  assign o_inst_data = w_q_data[r_rd_ptr];
  assign o_inst_pc   = w_q_pc[r_rd_ptr];

  // Occupancy, pointer and in-flight bookkeeping; flush clears all of it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count       <= 2'd0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
    end else if (i_flush) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= i_pc_address;
      end
    end
  end

  // One storage slot per queue entry, each holding {instruction, address}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic LP_IDX = 1'(gi);

    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Capture the returning read into this slot when the write pointer
    // selects it; entries are not cleared on flush since count guards them.
    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        r_data <= '0;
        r_pc   <= '0;
      end else if (w_write && (r_wr_ptr == LP_IDX)) begin
        r_data <= i_imem_rdata;
        r_pc   <= r_inflight_pc;
      end
    end

    assign w_q_data[gi] = r_data;
    assign w_q_pc[gi]   = r_pc;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch. A PC model steps by 4 on each pc_enable, a
// memory model returns addr + 0x100 one cycle after each read, and a
// reference model tracks fetched instructions as a list of {address, age}
// items: an item becomes visible to decode two edges after its issue and at
// most two items may be outstanding at once.
module tb_inst_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int VW = 3 + 2 * AW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_address;
  logic          pc_enable;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [DW-1:0] imem_rdata;
  logic          flush;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_pc_address (pc_address),
    .o_pc_enable  (pc_enable),
    .o_imem_addr  (imem_addr),
    .o_imem_en    (imem_en),
    .i_imem_rdata (imem_rdata),
    .i_flush      (flush),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready),
    .o_inst_data  (inst_data),
    .o_inst_pc    (inst_pc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            age;
  } item_t;

  item_t         mq[$];
  logic [AW-1:0] pc_model;
  int            npcen;
  logic [AW-1:0] deliv_pc[$];
  logic [DW-1:0] deliv_data[$];

  // Observed and expected values for the current cycle.
  logic          obs_valid, obs_pcen, obs_en;
  logic [AW-1:0] obs_pc, obs_addr;
  logic [DW-1:0] obs_data;
  logic          exp_valid, exp_pcen, exp_pop;
  logic [AW-1:0] exp_pc, exp_addr;
  logic [DW-1:0] exp_data;
  logic [VW-1:0] obs_vec, exp_vec;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a + 32'h100;
  endfunction

  // Settle, capture DUT outputs and compute what the model expects.
  task automatic sample();
    #1;
    obs_valid = inst_valid;
    obs_pcen  = pc_enable;
    obs_en    = imem_en;
    obs_addr  = imem_addr;
    obs_pc    = inst_pc;
    obs_data  = inst_data;
    exp_valid = (mq.size() > 0) && (mq[0].age >= 2);
    exp_pc    = exp_valid ? mq[0].addr : '0;
    exp_data  = exp_valid ? mem_word(mq[0].addr) : '0;
    exp_pop   = exp_valid && inst_ready && !flush;
    exp_pcen  = !flush && rst_n && ((mq.size() - (exp_pop ? 1 : 0)) < 2);
    exp_addr  = pc_address;
    obs_vec = {obs_valid, obs_pcen, obs_en, obs_addr,
               obs_valid ? obs_pc : {AW{1'b0}}, obs_valid ? obs_data : {DW{1'b0}}};
    exp_vec = {exp_valid, exp_pcen, exp_pcen, exp_addr, exp_pc, exp_data};
  endtask

  // Clock edge: record deliveries, step PC, memory and reference model.
  task automatic advance();
    item_t it;
    if (obs_valid && inst_ready && !flush) begin
      deliv_pc.push_back(obs_pc);
      deliv_data.push_back(obs_data);
      $display("deliver pc=%08h data=%08h", obs_pc, obs_data);
    end
    if (obs_pcen) npcen++;
    @(posedge clk);
    #1;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      if (exp_pop) void'(mq.pop_front());
      for (int i = 0; i < mq.size(); i++) mq[i].age++;
      if (exp_pcen) begin
        it.addr = exp_addr;
        it.age  = 1;
        mq.push_back(it);
      end
    end
    imem_rdata = obs_en ? mem_word(obs_addr) : $urandom();
    if (obs_pcen) pc_model = pc_model + 32'd4;
    pc_address = pc_model;
    @(negedge clk);
  endtask

  task automatic do_reset();
    flush      = 1'b0;
    inst_ready = 1'b0;
    rst_n      = 1'b0;
    mq.delete();
    pc_model   = '0;
    pc_address = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    deliv_pc.delete();
    deliv_data.delete();
    npcen = 0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b1;
    pc_model   = '0;
    pc_address = '0;
    imem_rdata = '0;
    npcen      = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if ({obs_valid, obs_pcen, obs_en, obs_pc, obs_data} !== {3'b000, {AW{1'b0}}, {DW{1'b0}}}) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: got valid=%b pcen=%b en=%b pc=%08h data=%08h, want all 0",
                 c, obs_valid, obs_pcen, obs_en, obs_pc, obs_data);
      end
      advance();
    end
    rst_n = 1'b1;
    sample();
    checks++;
    if (obs_pcen !== 1'b1 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got pcen=%b valid=%b, want pcen=1 valid=0", obs_pcen, obs_valid);
    end
    advance();
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int first_valid = -1;
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (obs_valid && first_valid < 0) first_valid = c;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stream cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL stream_latency: got first valid cycle %0d, want 2", first_valid);
    end
    checks++;
    if (deliv_pc.size() != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d deliveries, want 8", deliv_pc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (deliv_pc[k] !== 32'(4 * k) || deliv_data[k] !== 32'(4 * k + 32'h100)) begin
          errors++;
          $display("FAIL stream_order k=%0d: got {%08h,%08h} want {%08h,%08h}",
                   k, deliv_pc[k], deliv_data[k], 32'(4 * k), 32'(4 * k + 32'h100));
        end
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL backpressure cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (npcen != 2 || pc_model !== 32'd8) begin
      errors++;
      $display("FAIL bp_advances: got %0d pulses pc=%08h, want 2 pulses pc=00000008", npcen, pc_model);
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      if (c == 0) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_data !== 32'h100) begin
          errors++;
          $display("FAIL bp_head: got valid=%b {%08h,%08h} want 1 {00000000,00000100}",
                   obs_valid, obs_pc, obs_data);
        end
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bp_release cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (deliv_pc.size() != 3 || deliv_pc[0] !== 32'h0 || deliv_pc[1] !== 32'h4 || deliv_pc[2] !== 32'h8) begin
      errors++;
      $display("FAIL bp_order: got %0d deliveries, want pcs 0,4,8", deliv_pc.size());
    end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    int n0;
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL flush_pre cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    n0 = deliv_pc.size();
    flush = 1'b1;
    sample();
    checks++;
    if (obs_vec !== exp_vec || obs_pcen !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got %h want %h", obs_vec, exp_vec);
    end
    advance();
    flush      = 1'b0;
    pc_model   = 32'h40;
    pc_address = 32'h40;
    sample();
    checks++;
    if (obs_valid !== 1'b0 || obs_pcen !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: got valid=%b pcen=%b want valid=0 pcen=1", obs_valid, obs_pcen);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL flush_post cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (deliv_pc.size() != n0 + 2 || deliv_pc[n0] !== 32'h40 || deliv_data[n0] !== 32'h140) begin
      errors++;
      $display("FAIL flush_redirect: got %0d new deliveries first {%08h,%08h} want 2 first {00000040,00000140}",
               deliv_pc.size() - n0, (deliv_pc.size() > n0) ? deliv_pc[n0] : 32'hx,
               (deliv_pc.size() > n0) ? deliv_data[n0] : 32'hx);
    end
    $display("test_flush done");
  endtask

  task automatic test_flush_ready();
    int n0;
    do_reset();
    inst_ready = 1'b0;
    repeat (4) begin
      sample();
      advance();
    end
    inst_ready = 1'b1;
    flush      = 1'b1;
    n0 = deliv_pc.size();
    sample();
    checks++;
    if (obs_valid !== 1'b1 || obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL flush_ready_cycle: got %h want %h", obs_vec, exp_vec);
    end
    advance();
    flush = 1'b0;
    sample();
    checks++;
    if (deliv_pc.size() != n0 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_nopop: got %0d deliveries valid=%b want 0 deliveries valid=0",
               deliv_pc.size() - n0, obs_valid);
    end
    advance();
    $display("test_flush_ready done");
  endtask

  task automatic test_mid_reset();
    int n0;
    do_reset();
    inst_ready = 1'b1;
    repeat (5) begin
      sample();
      advance();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_enable !== 1'b0 || inst_pc !== '0 || inst_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%b pcen=%b pc=%08h data=%08h want all 0",
               inst_valid, pc_enable, inst_pc, inst_data);
    end
    mq.delete();
    pc_model   = '0;
    pc_address = '0;
    sample();
    advance();
    rst_n = 1'b1;
    n0 = deliv_pc.size();
    for (int c = 0; c < 6; c++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_reset_restart cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    checks++;
    if (deliv_pc.size() != n0 + 4 || deliv_pc[n0] !== 32'h0 || deliv_pc[n0 + 1] !== 32'h4) begin
      errors++;
      $display("FAIL mid_reset_order: got %0d deliveries after restart, want 4 starting at 0,4",
               deliv_pc.size() - n0);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    logic was_flush;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      was_flush  = flush;
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
      if (was_flush) begin
        pc_model   = $urandom() & 32'h0000_fffc;
        pc_address = pc_model;
      end
    end
    flush = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_ready();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
